// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and TX mux constants for the UART TX frame controller
//
// Contents:
//   tx_state_e  : 3-bit binary FSM encoding (IDLE=0 .. STOP=4)
//   SEL_*       : TX_OUT mux select codes
//   START_BIT / STOP_BIT : line levels for the framing bits
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] SEL_START  = 2'd0;
  localparam logic [1:0] SEL_DATA   = 2'd1;
  localparam logic [1:0] SEL_PARITY = 2'd2;
  localparam logic [1:0] SEL_STOP   = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - combinational even/odd parity over one data word
//
// Ports:
//   data     in  DATA_WIDTH  word to cover
//   odd      in  1           0 = even parity, 1 = odd parity
//   par_bit  out 1           parity bit to transmit
module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  par_bit
);

  // Even parity makes the total count of ones even; odd parity flips it.
  assign par_bit = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller sequencing the 8-bit serializer
//
// Ports:
//   clk         in   1           UART TX clock, one bit time per cycle
//   rst         in   1           asynchronous active-low reset
//   P_DATA      in   DATA_WIDTH  byte to send, sampled on accept
//   Data_Valid  in   1           upstream request
//   PAR_EN      in   1           parity enable, latched on accept
//   PAR_TYP     in   1           0 = even, 1 = odd, latched on accept
//   ser_data    in   1           serializer bit-0 output
//   ser_done    in   1           serializer last-bit flag
//   ser_load    out  1           serializer load strobe
//   ser_enable  out  1           serializer shift/count enable
//   TX_OUT      out  1           serial line, idle high
//   Busy        out  1           frame in progress
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_load,
  output logic                  ser_enable,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e  state_q, state_d;
  logic       par_bit, par_en_q;
  logic       par_calc;
  logic       accept;
  logic [1:0] tx_sel;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (P_DATA),
    .odd     (PAR_TYP),
    .par_bit (par_calc)
  );

  // A new frame can only be taken while idle or during the stop bit, which
  // gives back-to-back frames without ever reloading the serializer mid-frame.
  assign accept   = Data_Valid && (state_q == IDLE || state_q == STOP);
  assign ser_load = accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        par_bit  <= par_calc;
        par_en_q <= PAR_EN;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ser_enable = 1'b0;
    Busy       = 1'b1;
    tx_sel     = SEL_STOP;
    case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (accept) state_d = START;
      end
      START: begin
        tx_sel  = SEL_START;
        state_d = DATA;
      end
      DATA: begin
        tx_sel     = SEL_DATA;
        ser_enable = 1'b1;
        // A serializer that never raises ser_done parks the FSM here until reset.
        if (ser_done) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_sel  = SEL_PARITY;
        state_d = STOP;
      end
      STOP: begin
        state_d = accept ? START : IDLE;
      end
      default: begin
        Busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Line driver depends only on flops (state, par_bit, serializer shift reg).
  always_comb begin
    TX_OUT = STOP_BIT;
    case (tx_sel)
      SEL_START:  TX_OUT = START_BIT;
      SEL_DATA:   TX_OUT = ser_data;
      SEL_PARITY: TX_OUT = par_bit;
      default:    TX_OUT = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with a behavioural serializer
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_data, ser_done, ser_load, ser_enable, TX_OUT, Busy;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_load   (ser_load),
    .ser_enable (ser_enable),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Serializer: loads on ser_load, shifts LSB first while enabled, flags the 8th bit.
  logic [7:0] ser_sh;
  logic [2:0] ser_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_sh  <= 8'h00;
      ser_cnt <= 3'd0;
    end else if (ser_load) begin
      ser_sh  <= P_DATA;
      ser_cnt <= 3'd0;
    end else if (ser_enable) begin
      ser_sh  <= {1'b0, ser_sh[7:1]};
      ser_cnt <= ser_cnt + 3'd1;
    end
  end
  assign ser_data = ser_sh[0];
  assign ser_done = ser_enable && (ser_cnt == 3'd7);

  function automatic void check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void checkn(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected line levels for one frame, bit by bit from the hand-derived parity.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic ep);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(ep);
    exp_q.push_back(1'b1);
  endtask

  // Monitor: every Busy cycle must match the next expected bit; idle must be high.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Busy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_busy: got Busy=1 with no frame expected at %0t", $time);
        end else begin
          check1("tx_bit", TX_OUT, exp_q.pop_front());
        end
      end else begin
        check1("idle_tx", TX_OUT, 1'b1);
      end
    end
  end

  // Called at posedge+1; accept happens at the following posedge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic ep);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    #1;
    check1("ser_load_on_accept", ser_load, 1'b1);
    push_frame(d, pe, ep);
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    // Mid-frame changes to these must be ignored.
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checkn("drain_in_time", (n < 300) ? 1 : 0, 1);
    @(posedge clk); #1;
    check1("busy_low_after_frame", Busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #2;
    check1("reset_tx", TX_OUT, 1'b1);
    check1("reset_busy", Busy, 1'b0);
    check1("reset_ser_load", ser_load, 1'b0);
    check1("reset_ser_enable", ser_enable, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    check1("start_after_accept", TX_OUT, 1'b0);
    wait_drain();

    // 0x01 odd parity -> parity bit 0
    send(8'h01, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // 0x01 without parity -> 10-cycle frame
    send(8'h01, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back: second request during STOP of a 0x5A frame
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkn("reach_parity", (n < 50) ? 1 : 0, 1);
    @(posedge clk); #1;
    check1("in_stop_tx", TX_OUT, 1'b1);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    check1("b2b_start_no_gap", TX_OUT, 1'b0);
    check1("b2b_busy", Busy, 1'b1);
    wait_drain();

    // Request mid-DATA of a 0x00 frame must be dropped
    send(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    P_DATA = 8'hFF; Data_Valid = 1'b1;
    #1;
    check1("no_load_mid_data", ser_load, 1'b0);
    @(posedge clk); #1;
    check1("no_load_mid_data2", ser_load, 1'b0);
    Data_Valid = 1'b0;
    wait_drain();
    repeat (12) @(posedge clk);
    #1;
    checkn("ff_never_sent", exp_q.size(), 0);

    // Reset during DATA bit 4 of a 0xA5 frame, then a clean 0x55 frame
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check1("async_reset_tx", TX_OUT, 1'b1);
    check1("async_reset_busy", Busy, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(8'h55, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Continuous Data_Valid, no parity: accepts exactly 10 cycles apart
    P_DATA = 8'h96; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    #1;
    check1("hold_first_load", ser_load, 1'b1);
    push_frame(8'h96, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      n = 0;
      do begin
        @(posedge clk); #2;
        n++;
      end while (ser_load == 1'b0 && n < 20);
      checkn("hold_frame_spacing", n, 10);
      push_frame(8'h96, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    wait_drain();

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
